// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - in-order ALU instruction FIFO with RAW scoreboard issue check
// Optional hazard-stall counter built when ISSUE_PERF_CNT_EN is defined.
module alu_issue_unit #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic        iss_valid,
    output logic [3:0]  iss_func,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [7:0]  iss_addr,
    output logic        illegal,
    output logic        busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [23:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [WB_LAT-1:0] sb_valid;
    logic [3:0]        sb_rd [WB_LAT];

    logic [23:0] head;
    logic [3:0]  h_func;
    logic [3:0]  h_rd;
    logic [3:0]  h_rs1;
    logic [3:0]  h_rs2;
    logic [7:0]  h_addr;
    logic        head_present;
    logic        head_illegal;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        do_issue;
    logic        do_drop;
    logic        push;
    logic        pop;

    assign head         = mem[rd_ptr];
    assign h_func       = head[23:20];
    assign h_rd         = head[19:16];
    assign h_rs1        = head[15:12];
    assign h_rs2        = head[11:8];
    assign h_addr       = head[7:0];
    assign head_present = (count != '0);
    assign head_illegal = (h_func >= 4'd12);

    // Source usage decode; illegal opcodes read nothing.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (h_func)
            4'd3, 4'd8, 4'd10, 4'd11:                use_rs1 = 1'b1;
            4'd4, 4'd9:                              use_rs2 = 1'b1;
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Any in-flight write-back to a register the head reads blocks issue.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_valid[i] && ((use_rs1 && (sb_rd[i] == h_rs1)) ||
                                (use_rs2 && (sb_rd[i] == h_rs2))))
                hazard = 1'b1;
        end
    end

    assign do_issue = head_present && !head_illegal && !hazard;
    assign do_drop  = head_present && head_illegal;
    assign pop      = do_issue || do_drop;
    assign in_ready = rst_n && (count < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign busy     = head_present || (|sb_valid);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sb_valid  <= '0;
            for (int i = 0; i < WB_LAT; i++)
                sb_rd[i] <= '0;
            iss_valid <= 1'b0;
            iss_func  <= '0;
            iss_rd    <= '0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_addr  <= '0;
            illegal   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            for (int i = WB_LAT - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= do_issue;
            sb_rd[0]    <= h_rd;

            iss_valid <= do_issue;
            illegal   <= do_drop;
            if (do_issue) begin
                iss_func <= h_func;
                iss_rd   <= h_rd;
                iss_rs1  <= h_rs1;
                iss_rs2  <= h_rs2;
                iss_addr <= h_addr;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (head_present && !head_illegal && hazard && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed plus random check of alu_issue_unit against a ready-time model
module tb_alu_issue_unit;

    localparam int DEPTH  = 4;
    localparam int WB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_instr = '0;
    logic        in_ready;
    logic        iss_valid;
    logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
    logic [7:0]  iss_addr;
    logic        illegal;
    logic        busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    alu_issue_unit #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .iss_valid(iss_valid), .iss_func(iss_func),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_addr(iss_addr), .illegal(illegal), .busy(busy)
`ifdef ISSUE_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: queue of pending instructions plus, per register, the first edge
    // at which a reader of it may issue.
    logic [23:0] mq [$];
    int          ready_t [16];
    int          cyc = 0;
    int          last_iss = -1000;
    logic        e_iv, e_ill;
    logic [3:0]  e_func, e_rd, e_rs1, e_rs2;
    logic [7:0]  e_addr;
    int          e_stall = 0;

    function automatic bit reads1(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
    endfunction

    function automatic bit reads2(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    endfunction

    function automatic logic [23:0] ins(input int f, input int rd, input int r1, input int r2, input int a);
        return {4'(f), 4'(rd), 4'(r1), 4'(r2), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [23:0] instr);
        logic        exp_rdy;
        logic [23:0] h;
        logic [3:0]  f;
        bit          ok;
        @(negedge clk);
        rst_n    = !rst;
        in_valid = v;
        in_instr = instr;
        #1;
        exp_rdy = !rst && (mq.size() < DEPTH);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
        cyc++;
        e_iv  = 1'b0;
        e_ill = 1'b0;
        if (rst) begin
            mq.delete();
            foreach (ready_t[i]) ready_t[i] = 0;
            last_iss = -1000;
            {e_func, e_rd, e_rs1, e_rs2, e_addr} = '0;
            e_stall = 0;
        end else begin
            if (mq.size() > 0) begin
                h = mq[0];
                f = h[23:20];
                if (f >= 4'd12) begin
                    void'(mq.pop_front());
                    e_ill = 1'b1;
                end else begin
                    ok = (!reads1(f) || ready_t[h[15:12]] <= cyc) &&
                         (!reads2(f) || ready_t[h[11:8]] <= cyc);
                    if (ok) begin
                        void'(mq.pop_front());
                        e_iv = 1'b1;
                        {e_func, e_rd, e_rs1, e_rs2, e_addr} = h;
                        ready_t[h[19:16]] = cyc + WB_LAT + 1;
                        last_iss = cyc;
                    end else if (e_stall < 16'hFFFF) begin
                        e_stall++;
                    end
                end
            end
            if (v && exp_rdy)
                mq.push_back(instr);
        end
        chk("iss_valid", iss_valid, e_iv);
        chk("illegal", illegal, e_ill);
        chk("iss_fields", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr},
            {e_func, e_rd, e_rs1, e_rs2, e_addr});
        chk("busy", busy, (mq.size() != 0) || (cyc - last_iss < WB_LAT));
`ifdef ISSUE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e_stall);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0);
    endtask

    initial begin
        // reset with in_valid asserted, then idle
        step(1, 1, ins(0, 1, 2, 3, 8'h11));
        step(1, 1, ins(0, 1, 2, 3, 8'h11));
        idle(1);

        // independent stream
        step(0, 1, ins(0, 1, 2, 3, 8'h10));
        step(0, 1, ins(1, 4, 5, 6, 8'h20));
        step(0, 1, ins(2, 7, 8, 9, 8'h30));
        idle(5);

        // RAW through rs1 (SELA) and rs2 (SELB), then SELA with unused rs2
        step(1, 0, '0);
        step(0, 1, ins(0, 3, 1, 2, 8'h40));
        step(0, 1, ins(3, 5, 3, 0, 8'h41));
        idle(7);
        step(0, 1, ins(0, 3, 1, 2, 8'h42));
        step(0, 1, ins(4, 5, 0, 3, 8'h43));
        idle(7);
        step(0, 1, ins(0, 3, 1, 2, 8'h44));
        step(0, 1, ins(3, 5, 0, 3, 8'h45));
        idle(5);

        // full FIFO behind a hazard; fifth push attempt must be rejected
        step(0, 1, ins(0, 3, 1, 2, 8'h50));
        for (int i = 0; i < 5; i++)
            step(0, 1, ins(1, 8 + i, 3, 0, 8'h51 + i));
        idle(8);

        // illegal opcode then legal
        step(0, 1, ins(13, 2, 1, 1, 8'h60));
        step(0, 1, ins(0, 6, 1, 1, 8'h61));
        idle(4);

        // reset mid-stall with three queued entries
        step(0, 1, ins(0, 3, 1, 2, 8'h70));
        step(0, 1, ins(0, 4, 3, 3, 8'h71));
        step(0, 1, ins(0, 5, 3, 3, 8'h72));
        step(0, 1, ins(0, 6, 3, 3, 8'h73));
        step(1, 0, '0);
        idle(6);

        // random traffic over a narrow register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 ins($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 255)));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
